// File: rtl/frame_dump_unit.sv
// -----------------------------------------------------------------------------
// frame_dump_unit
//   Streams a block of memory words out as a sequence of UART-sized bytes.
//   On i_start (IDLE only) the unit latches base address, word count, byte
//   order and separator enable. It then reads each word, splits it into
//   DATA_SIZE/UART_DATA_SIZE bytes and optionally appends SYN_BYTE after each
//   word. Each byte is presented with o_valid high for VALID_HOLD cycles, and
//   the unit then waits for i_ready before moving on.
//
// Ports
//   i_clock      : clock, rising edge
//   i_reset_n    : synchronous active-low reset
//   i_start      : start-frame request (IDLE only)
//   i_abort      : abort the active frame, back to IDLE with no o_done
//   i_base_addr  : first word address (latched at start)
//   i_length     : number of words (latched at start)
//   i_msb_first  : 1 = most-significant byte first (latched at start)
//   i_syn_en     : 1 = append SYN_BYTE after each word (latched at start)
//   i_ready      : UART transmitter ready
//   i_mem_data   : memory read data, valid one cycle after o_addr changes
//   o_addr       : registered memory read address
//   o_data       : registered byte to transmit
//   o_valid      : byte-valid strobe
//   o_busy       : high whenever the FSM is not in IDLE
//   o_done       : one-cycle pulse on normal frame completion
// -----------------------------------------------------------------------------
module frame_dump_unit #(
  parameter int unsigned               ADDR_SIZE      = 12,
  parameter int unsigned               DATA_SIZE      = 16,
  parameter int unsigned               UART_DATA_SIZE = 8,
  parameter logic [UART_DATA_SIZE-1:0] SYN_BYTE       = 8'hFF,
  parameter int unsigned               VALID_HOLD     = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [ADDR_SIZE-1:0]      i_base_addr,
  input  logic [ADDR_SIZE:0]        i_length,
  input  logic                      i_msb_first,
  input  logic                      i_syn_en,
  input  logic                      i_ready,
  input  logic [DATA_SIZE-1:0]      i_mem_data,
  output logic [ADDR_SIZE-1:0]      o_addr,
  output logic [UART_DATA_SIZE-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned NBYTES = DATA_SIZE / UART_DATA_SIZE;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned HOLD   = (VALID_HOLD > 0) ? VALID_HOLD : 1;
  localparam int unsigned HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned LW     = ADDR_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MEM = 3'd1,
    LOAD     = 3'd2,
    VALID    = 3'd3,
    SEND     = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic [UART_DATA_SIZE-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [DATA_SIZE-1:0]      word_q, word_d;
  logic [BW-1:0]             byte_idx_q, byte_idx_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [LW-1:0]             wcnt_q, wcnt_d;
  logic [LW-1:0]             len_q, len_d;
  logic                      msb_q, msb_d;
  logic                      syn_q, syn_d;
  logic                      syn_sent_q, syn_sent_d;

  // Select the idx-th transmitted byte of a word for the given byte order.
  function automatic logic [UART_DATA_SIZE-1:0] pick_byte(
    input logic [DATA_SIZE-1:0] w,
    input logic [BW-1:0]        idx,
    input logic                 msb
  );
    logic [BW-1:0]             pos;
    logic [UART_DATA_SIZE-1:0] b;
    pos = msb ? (BW'(NBYTES - 1) - idx) : idx;
    b   = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (pos == BW'(i)) begin
        b = w[i*UART_DATA_SIZE +: UART_DATA_SIZE];
      end
    end
    return b;
  endfunction

  // State and datapath registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= '0;
      byte_idx_q <= '0;
      hold_q     <= '0;
      wcnt_q     <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      syn_q      <= 1'b0;
      syn_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      hold_q     <= hold_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      msb_q      <= msb_d;
      syn_q      <= syn_d;
      syn_sent_q <= syn_sent_d;
    end
  end

  // Next-state and next-output logic. Strobes default low; they are set
  // on the transition into the state that owns them so they line up with it.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    hold_d     = hold_q;
    wcnt_d     = wcnt_q;
    len_d      = len_q;
    msb_d      = msb_q;
    syn_d      = syn_q;
    syn_sent_d = syn_sent_q;

    if ((state_q != IDLE) && i_abort) begin
      // Abort wins over every transition, including the DONE exit.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            len_d  = i_length;
            msb_d  = i_msb_first;
            syn_d  = i_syn_en;
            addr_d = i_base_addr;
            wcnt_d = '0;
            if (i_length == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT_MEM;
            end
          end
        end

        // Memory data for the new address becomes valid during LOAD.
        WAIT_MEM: state_d = LOAD;

        LOAD: begin
          word_d     = i_mem_data;
          data_d     = pick_byte(i_mem_data, '0, msb_q);
          byte_idx_d = '0;
          syn_sent_d = 1'b0;
          hold_d     = '0;
          valid_d    = 1'b1;
          state_d    = VALID;
        end

        VALID: begin
          if (hold_q == HW'(HOLD - 1)) begin
            state_d = SEND;
          end else begin
            hold_d  = hold_q + HW'(1);
            valid_d = 1'b1;
          end
        end

        SEND: begin
          if (i_ready) begin
            if (byte_idx_q != BW'(NBYTES - 1)) begin
              byte_idx_d = byte_idx_q + BW'(1);
              data_d     = pick_byte(word_q, byte_idx_q + BW'(1), msb_q);
              hold_d     = '0;
              valid_d    = 1'b1;
              state_d    = VALID;
            end else if (syn_q && !syn_sent_q) begin
              data_d     = SYN_BYTE;
              syn_sent_d = 1'b1;
              hold_d     = '0;
              valid_d    = 1'b1;
              state_d    = VALID;
            end else if ((wcnt_q + LW'(1)) == len_q) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              // Address wraps naturally at 2^ADDR_SIZE.
              wcnt_d  = wcnt_q + LW'(1);
              addr_d  = addr_q + ADDR_SIZE'(1);
              state_d = WAIT_MEM;
            end
          end
        end

        DONE: state_d = IDLE;

        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_frame_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_frame_dump_unit
//   Directed bench for frame_dump_unit: a table of frame records (inputs plus
//   the expected byte and address streams) applied in a loop, followed by
//   hand-written sequences for latency, back-pressure, abort, zero length
//   and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_frame_dump_unit;

  localparam int unsigned VH = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        msb_first;
  logic        syn_en;
  logic        ready;
  logic [15:0] mem_data;
  logic [11:0] o_addr;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;

  frame_dump_unit dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_start     (start),
    .i_abort     (abort),
    .i_base_addr (base_addr),
    .i_length    (length),
    .i_msb_first (msb_first),
    .i_syn_en    (syn_en),
    .i_ready     (ready),
    .i_mem_data  (mem_data),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: one cycle of read latency.
  logic [15:0] mem [0:4095];
  always @(posedge clk) mem_data <= mem[o_addr];

  // Frame record: expected bytes and addresses packed first-to-last, left to right.
  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    logic        msb;
    logic        syn;
    int          nb;
    logic [95:0] bytes;
    int          na;
    logic [47:0] addrs;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Monitor state, sampled on the falling edge.
  logic [7:0]  got_bytes[$];
  logic [11:0] got_addrs[$];
  int          done_cnt = 0;
  int          run_bad  = 0;
  int          run_len  = 0;
  logic [7:0]  run_data = '0;
  logic        prev_v   = 1'b0;
  logic        prev_b   = 1'b0;
  logic [11:0] prev_a   = '0;

  always @(negedge clk) begin
    if (o_valid) begin
      if (!prev_v) begin
        got_bytes.push_back(o_data);
        run_len  = 1;
        run_data = o_data;
      end else begin
        run_len = run_len + 1;
        if (o_data !== run_data) run_bad = run_bad + 1;
      end
    end else if (prev_v && (run_len != int'(VH))) begin
      run_bad = run_bad + 1;
    end
    if (o_busy && (!prev_b || (o_addr != prev_a))) got_addrs.push_back(o_addr);
    if (o_done) done_cnt = done_cnt + 1;
    prev_v = o_valid;
    prev_b = o_busy;
    prev_a = o_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_bytes.delete();
    got_addrs.delete();
    done_cnt = 0;
    run_bad  = 0;
  endtask

  task automatic set_inputs(input vec_t v);
    base_addr = v.base;
    length    = v.len;
    msb_first = v.msb;
    syn_en    = v.syn;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (o_busy && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(o_busy), 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int count, input int budget);
    int n;
    n = 0;
    while ((got_bytes.size() < count) && (n < budget)) begin
      step();
      n++;
    end
    chk({tag, "_byte_timeout"}, 32'(got_bytes.size() >= count), 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    set_inputs(v);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(tag, 400);
  endtask

  task automatic compare_frame(input vec_t v, input string tag);
    chk({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(v.nb));
    for (int i = 0; (i < v.nb) && (i < got_bytes.size()); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(v.bytes[(v.nb-1-i)*8 +: 8]));
    chk({tag, "_naddr"}, 32'(got_addrs.size()), 32'(v.na));
    for (int i = 0; (i < v.na) && (i < got_addrs.size()); i++)
      chk($sformatf("%s_addr%0d", tag, i), 32'(got_addrs[i]), 32'(v.addrs[(v.na-1-i)*12 +: 12]));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_valid_runs"}, 32'(run_bad), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'hABCD;
    mem[12'h011] = 16'h1234;
    mem[12'h012] = 16'h00FF;
    mem[12'hFFF] = 16'h9876;
    mem[12'h000] = 16'h0F1E;
    mem[12'h020] = 16'hC3B4;

    vecs[0] = '{12'h010, 13'd2, 1'b1, 1'b1, 6, 96'hABCDFF1234FF,       2, 48'h010011};
    vecs[1] = '{12'h010, 13'd2, 1'b0, 1'b0, 4, 96'hCDAB3412,           2, 48'h010011};
    vecs[2] = '{12'hFFF, 13'd2, 1'b1, 1'b0, 4, 96'h98760F1E,           2, 48'hFFF000};
    vecs[3] = '{12'h020, 13'd1, 1'b0, 1'b1, 3, 96'hB4C3FF,             1, 48'h020};
    vecs[4] = '{12'h030, 13'd0, 1'b1, 1'b1, 0, 96'h0,                  1, 48'h030};
    vecs[5] = '{12'h010, 13'd3, 1'b1, 1'b1, 9, 96'hABCDFF1234FF00FFFF, 3, 48'h010011012};

    // Reset, with i_start asserted to show it is ignored under reset.
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; ready = 1'b1;
    base_addr = 12'h5A5; length = 13'd3; msb_first = 1'b1; syn_en = 1'b1;
    step(); step(); step();
    chk("rst_addr",  32'(o_addr),  32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_done",  32'(o_done),  32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      run_frame(vecs[i], $sformatf("vec%0d", i));
      step();
      compare_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Latency: start sampled at edge E, o_valid low after E+1, high after E+2.
    // Also scramble the start inputs and re-pulse i_start mid-frame.
    clear_mon();
    set_inputs(vecs[0]);
    start = 1'b1;
    step();
    chk("lat_busy",   32'(o_busy),  32'd1);
    chk("lat_addr",   32'(o_addr),  32'h010);
    chk("lat_valid1", 32'(o_valid), 32'd0);
    base_addr = 12'h500; length = 13'd7; msb_first = 1'b0; syn_en = 1'b0;
    step();
    chk("lat_valid2", 32'(o_valid), 32'd0);
    start = 1'b0;
    step();
    chk("lat_valid3", 32'(o_valid), 32'd1);
    chk("lat_data",   32'(o_data),  32'hAB);
    wait_idle("lat", 400);
    step();
    compare_frame(vecs[0], "latch");

    // Back-pressure: i_ready low for 20 cycles after the first byte.
    clear_mon();
    ready = 1'b0;
    set_inputs(vecs[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_bytes("stall", 1, 20);
    for (int i = 0; i < 20; i++) step();
    chk("stall_valid",  32'(o_valid),          32'd0);
    chk("stall_data",   32'(o_data),           32'hAB);
    chk("stall_addr",   32'(o_addr),           32'h010);
    chk("stall_nbytes", 32'(got_bytes.size()), 32'd1);
    ready = 1'b1;
    wait_idle("stall", 400);
    step();
    compare_frame(vecs[0], "stall");

    // Abort during the second byte, then a clean frame.
    clear_mon();
    set_inputs(vecs[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_bytes("abort", 2, 40);
    abort = 1'b1;
    step();
    chk("abort_busy",  32'(o_busy),  32'd0);
    chk("abort_valid", 32'(o_valid), 32'd0);
    abort = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_done_cnt", 32'(done_cnt),         32'd0);
    chk("abort_nbytes",   32'(got_bytes.size()), 32'd2);
    chk("abort_idle",     32'(o_busy),           32'd0);
    clear_mon();
    run_frame(vecs[0], "after_abort");
    step();
    compare_frame(vecs[0], "after_abort");

    // Zero length: o_done on the cycle after start, no o_valid.
    clear_mon();
    set_inputs(vecs[4]);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_done1",  32'(o_done),  32'd1);
    chk("len0_busy1",  32'(o_busy),  32'd1);
    chk("len0_valid1", 32'(o_valid), 32'd0);
    step();
    chk("len0_done2",  32'(o_done),  32'd0);
    chk("len0_busy2",  32'(o_busy),  32'd0);
    chk("len0_nbytes", 32'(got_bytes.size()), 32'd0);

    // Reset mid-frame with i_start held high.
    clear_mon();
    set_inputs(vecs[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_bytes("mrst", 1, 20);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    chk("mrst_addr",  32'(o_addr),  32'd0);
    chk("mrst_data",  32'(o_data),  32'd0);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_busy",  32'(o_busy),  32'd0);
    chk("mrst_done",  32'(o_done),  32'd0);
    step(); step();
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mrst_idle",     32'(o_busy),           32'd0);
    chk("mrst_done_cnt", 32'(done_cnt),         32'd0);
    chk("mrst_nbytes",   32'(got_bytes.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
